rx_activity_blink: RTL and testbench

//  Turns receive-OK activity on one port into a fixed-rhythm LED blink enable
//    (blink_on_time), consumed by the port LED-control stage.

---
 rtl/rx_activity_blink.sv | 100 ++++++++++
 tb/tb_rx_activity_blink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_activity_blink.sv
// Receive-activity LED blinker: each accepted rx_ok rising edge produces one
// ON/OFF blink measured in prescaled ticks; activity during a blink queues one more.
module rx_activity_blink #(
  parameter int PRESCALE_DIV = 50000,
  parameter int ON_TICKS     = 30,
  parameter int OFF_TICKS    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_done,
  input  logic       rx_ok,
  output logic       blink_on_time,
  output logic       busy,
  output logic [7:0] rx_cnt
);

  // Width floors at 1 so single-valued bounds still get a legal vector.
  localparam int PW   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t          state, state_nxt;
  logic            pending, pending_nxt;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   tick_cnt;
  logic            rx_ok_d;
  logic            acc_edge;
  logic            tick;

  assign acc_edge = rx_ok & ~rx_ok_d & c_done;
  assign tick     = (state != IDLE) && (presc == PRE_LAST);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (!c_done) begin
      state_nxt   = IDLE;
      pending_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (acc_edge) state_nxt = ON;
        ON: begin
          if (acc_edge) pending_nxt = 1'b1;
          if (tick && tick_cnt == ON_LAST) state_nxt = OFF;
        end
        OFF: begin
          if (tick && tick_cnt == OFF_LAST) begin
            // Edge on the final OFF cycle counts the same as a queued one.
            if (pending || acc_edge) begin
              state_nxt   = ON;
              pending_nxt = 1'b0;
            end else begin
              state_nxt   = IDLE;
            end
          end else if (acc_edge) begin
            pending_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      presc         <= '0;
      tick_cnt      <= '0;
      rx_ok_d       <= 1'b0;
      rx_cnt        <= 8'd0;
      blink_on_time <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      rx_ok_d       <= rx_ok;
      blink_on_time <= (state_nxt == ON);
      busy          <= (state_nxt != IDLE);
      if (acc_edge) rx_cnt <= rx_cnt + 8'd1;
      // Restarting the prescaler on every transition keeps phase lengths exact.
      if (state_nxt != state || state == IDLE) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + TW'(1);
      end else begin
        presc    <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_activity_blink.sv
// Bench for rx_activity_blink: two configurations driven in lockstep and compared
// each cycle against a cycle-countdown reference model, plus directed scenarios.
module tb_rx_activity_blink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c_done = 1'b1;
  logic       rx_ok = 1'b0;
  logic       blink0, busy0, blink1, busy1;
  logic [7:0] cnt0, cnt1;

  always #5 clk = ~clk;

  rx_activity_blink #(.PRESCALE_DIV(4), .ON_TICKS(3), .OFF_TICKS(2)) u_dut0 (
    .clk(clk), .rst(rst), .c_done(c_done), .rx_ok(rx_ok),
    .blink_on_time(blink0), .busy(busy0), .rx_cnt(cnt0)
  );

  rx_activity_blink #(.PRESCALE_DIV(1), .ON_TICKS(1), .OFF_TICKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .c_done(c_done), .rx_ok(rx_ok),
    .blink_on_time(blink1), .busy(busy1), .rx_cnt(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: each phase is a plain countdown of clk cycles.
  localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2;
  int pd [2] = '{4, 1};
  int ont[2] = '{3, 1};
  int oft[2] = '{2, 1};
  int m_mode[2] = '{0, 0};
  int m_rem [2] = '{0, 0};
  bit m_pend[2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_prev = 1'b0;

  task automatic model_step();
    bit e;
    e = rx_ok && !m_prev;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = M_IDLE; m_rem[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
      end else if (!c_done) begin
        m_mode[i] = M_IDLE; m_rem[i] = 0; m_pend[i] = 0;
      end else begin
        if (e) m_cnt[i] = (m_cnt[i] + 1) % 256;
        case (m_mode[i])
          M_IDLE: if (e) begin m_mode[i] = M_ON; m_rem[i] = ont[i] * pd[i]; end
          M_ON: begin
            if (e) m_pend[i] = 1;
            m_rem[i]--;
            if (m_rem[i] == 0) begin m_mode[i] = M_OFF; m_rem[i] = oft[i] * pd[i]; end
          end
          default: begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
              if (m_pend[i] || e) begin
                m_mode[i] = M_ON; m_rem[i] = ont[i] * pd[i]; m_pend[i] = 0;
              end else begin
                m_mode[i] = M_IDLE;
              end
            end else if (e) begin
              m_pend[i] = 1;
            end
          end
        endcase
      end
    end
    m_prev = rst ? 1'b0 : rx_ok;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("blink0", blink0, (m_mode[0] == M_ON));
    chk("busy0",  busy0,  (m_mode[0] != M_IDLE));
    chk("cnt0",   cnt0,   m_cnt[0]);
    chk("blink1", blink1, (m_mode[1] == M_ON));
    chk("busy1",  busy1,  (m_mode[1] != M_IDLE));
    chk("cnt1",   cnt1,   m_cnt[1]);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_ok = 1'b0; c_done = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic pulse();
    rx_ok = 1'b1;
    cycle();
    rx_ok = 1'b0;
  endtask

  // Starts in the first ON cycle; mask bit k injects a pulse at iteration k.
  task automatic blink_run(input logic [31:0] mask, output int rises, output int blen);
    bit prevb;
    rises = 1; blen = 1; prevb = 1'b1;
    for (int k = 0; k < 300 && busy0; k++) begin
      rx_ok = (k < 32) ? mask[k] : 1'b0;
      cycle();
      if (busy0) blen++;
      if (blink0 && !prevb) rises++;
      prevb = blink0;
    end
    rx_ok = 1'b0;
  endtask

  task automatic count_busy(input int n, output int nb);
    nb = 0;
    repeat (n) begin
      cycle();
      if (busy0 || busy1) nb++;
    end
  endtask

  initial begin
    int n, m, rises, blen, nb;

    // Reset state
    cycle();
    chk("rst_blink", blink0, 0);
    chk("rst_busy",  busy0,  0);
    chk("rst_cnt",   cnt0,   0);
    rst = 1'b0;

    // Single pulse: latency 1, 12-cycle ON, 8-cycle OFF
    run(3);
    pulse();
    chk("s1_latency", blink0, 1);
    n = 1;
    for (int k = 0; k < 100 && blink0; k++) begin
      cycle();
      if (blink0) n++;
    end
    chk("s1_on_len", n, 12);
    m = 0;
    for (int k = 0; k < 100 && busy0 && !blink0; k++) begin
      m++;
      cycle();
    end
    chk("s1_off_len", m, 8);
    chk("s1_idle", busy0, 0);
    chk("s1_cnt", cnt0, 1);

    // Second pulse during ON: back-to-back blink, busy never drops
    do_reset();
    pulse();
    blink_run(32'h0000_0008, rises, blen);
    chk("s2_blinks", rises, 2);
    chk("s2_busy_len", blen, 40);
    chk("s2_cnt", cnt0, 2);

    // Five pulses collapse into one extra blink
    do_reset();
    pulse();
    blink_run(32'h0000_8888, rises, blen);
    chk("s3_blinks", rises, 2);
    chk("s3_busy_len", blen, 40);
    chk("s3_cnt", cnt0, 5);

    // c_done drop mid-ON; raise with rx_ok already high gives no blink
    do_reset();
    pulse();
    run(4);
    c_done = 1'b0;
    cycle();
    chk("s4_blink", blink0, 0);
    chk("s4_busy", busy0, 0);
    rx_ok = 1'b1;
    run(3);
    c_done = 1'b1;
    count_busy(40, nb);
    chk("s4_noblink", nb, 0);
    chk("s4_cnt", cnt0, 1);
    rx_ok = 1'b0;
    cycle();

    // Reset mid-OFF with a pending blink queued
    do_reset();
    pulse();
    run(3);
    pulse();
    for (int k = 0; k < 100 && blink0; k++) cycle();
    run(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("s5_blink", blink0, 0);
    chk("s5_busy", busy0, 0);
    chk("s5_cnt", cnt0, 0);
    count_busy(40, nb);
    chk("s5_noblink", nb, 0);

    // Pulse on the last OFF cycle goes straight to ON
    do_reset();
    pulse();
    for (int k = 0; k < 100 && blink0; k++) cycle();
    run(7);
    chk("s6_still_off", {busy0, blink0}, 2'b10);
    pulse();
    chk("s6_direct_on", blink0, 1);
    for (int k = 0; k < 100 && busy0; k++) cycle();

    // rx_cnt wraps 255 -> 0
    do_reset();
    repeat (255) begin
      pulse();
      cycle();
    end
    chk("wrap_255", cnt0, 255);
    pulse();
    chk("wrap_0", cnt0, 0);
    chk("wrap_0_small", cnt1, 0);

    // Minimal configuration: one-cycle ON, one-cycle OFF
    do_reset();
    run(2);
    pulse();
    chk("s7_on", blink1, 1);
    cycle();
    chk("s7_off_blink", blink1, 0);
    chk("s7_off_busy", busy1, 1);
    cycle();
    chk("s7_idle", busy1, 0);

    // Randomized bursty traffic with occasional c_done drops and resets
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = (blk % 2 == 0) ? 4 : 60;
      for (int k = 0; k < 200; k++) begin
        rx_ok  = ($urandom_range(0, dens - 1) == 0);
        c_done = ($urandom_range(0, 149) != 0);
        rst    = ($urandom_range(0, 599) == 0);
        cycle();
      end
    end
    rst = 1'b0; c_done = 1'b1; rx_ok = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
